// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: ALU ops, sequencer states, opcode map
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_OP_AND            = 4'd0,
        ALU_OP_XOR            = 4'd1,
        ALU_OP_SUB            = 4'd2,
        ALU_OP_SUB_REVERSED   = 4'd3,
        ALU_OP_ADD            = 4'd4,
        ALU_OP_ADC            = 4'd5,
        ALU_OP_SBC            = 4'd6,
        ALU_OP_SBC_REVERSED   = 4'd7,
        ALU_OP_TEST           = 4'd8,
        ALU_OP_TEST_EXCLUSIVE = 4'd9,
        ALU_OP_CMP            = 4'd10,
        ALU_OP_CMP_NEG        = 4'd11,
        ALU_OP_OR             = 4'd12,
        ALU_OP_MOV            = 4'd13,
        ALU_OP_BIT_CLEAR      = 4'd14,
        ALU_OP_NOT            = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REG_SHIFT = 2'd1,
        EXEC      = 2'd2
    } seq_state_t;

    localparam logic [3:0] REG_PC = 4'd15;

    function automatic alu_op_t dp_opcode_to_alu_op(input logic [3:0] opcode);
        alu_op_t op;
        case (opcode)
            4'h0:    op = ALU_OP_AND;
            4'h1:    op = ALU_OP_XOR;
            4'h2:    op = ALU_OP_SUB;
            4'h3:    op = ALU_OP_SUB_REVERSED;
            4'h4:    op = ALU_OP_ADD;
            4'h5:    op = ALU_OP_ADC;
            4'h6:    op = ALU_OP_SBC;
            4'h7:    op = ALU_OP_SBC_REVERSED;
            4'h8:    op = ALU_OP_TEST;
            4'h9:    op = ALU_OP_TEST_EXCLUSIVE;
            4'hA:    op = ALU_OP_CMP;
            4'hB:    op = ALU_OP_CMP_NEG;
            4'hC:    op = ALU_OP_OR;
            4'hD:    op = ALU_OP_MOV;
            4'hE:    op = ALU_OP_BIT_CLEAR;
            default: op = ALU_OP_NOT;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - decoder-to-sequencer fields and sequencer datapath controls
interface alu_sequencer_if;
    import cpu_types_pkg::*;

    logic       start;
    logic [3:0] opcode;
    logic       set_flags;
    logic       shift_by_reg;
    logic [3:0] rd;
    logic       cancel;

    logic       busy;
    logic       done;
    alu_op_t    alu_op;
    logic       latch_op_b;
    logic       use_op_b_latch;
    logic       disable_op_b;
    logic       rs_read;
    logic       rd_we;
    logic [3:0] rd_idx;
    logic       flags_we;
    logic       spsr_to_cpsr;
    logic       flush_req;

    modport master (
        output start, opcode, set_flags, shift_by_reg, rd, cancel,
        input  busy, done, alu_op, latch_op_b, use_op_b_latch, disable_op_b,
               rs_read, rd_we, rd_idx, flags_we, spsr_to_cpsr, flush_req
    );

    modport slave (
        input  start, opcode, set_flags, shift_by_reg, rd, cancel,
        output busy, done, alu_op, latch_op_b, use_op_b_latch, disable_op_b,
               rs_read, rd_we, rd_idx, flags_we, spsr_to_cpsr, flush_req
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - steps one data-processing instruction through the shared ALU datapath
module alu_sequencer
    import cpu_types_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    alu_sequencer_if.slave  bus
);

    seq_state_t state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic       set_flags_q, set_flags_d;
    logic       shift_q, shift_d;
    logic [3:0] rd_q, rd_d;
    logic       accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            opcode_q    <= 4'hD;
            set_flags_q <= 1'b0;
            shift_q     <= 1'b0;
            rd_q        <= 4'd0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            set_flags_q <= set_flags_d;
            shift_q     <= shift_d;
            rd_q        <= rd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        set_flags_d = set_flags_q;
        shift_d     = shift_q;
        rd_d        = rd_q;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = bus.shift_by_reg ? REG_SHIFT : EXEC;
                end
            end
            REG_SHIFT: state_d = EXEC;
            EXEC:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (bus.cancel) begin
            accept  = 1'b0;
            state_d = IDLE;
        end
        if (accept) begin
            opcode_d    = bus.opcode;
            set_flags_d = bus.set_flags;
            shift_d     = bus.shift_by_reg;
            rd_d        = bus.rd;
        end
    end

    logic kill, is_compare, rd_is_pc;
    logic busy, done, latch_op_b, use_op_b_latch, rs_read;
    logic rd_we, flags_we, spsr_to_cpsr, flush_req;

    // cancel and reset suppress every side-effecting strobe in the cycle they arrive
    always_comb begin
        kill           = bus.cancel | reset;
        is_compare     = (opcode_q[3:2] == 2'b10);
        rd_is_pc       = (rd_q == REG_PC);
        busy           = (state_q != IDLE);
        done           = 1'b0;
        latch_op_b     = 1'b0;
        use_op_b_latch = 1'b0;
        rs_read        = 1'b0;
        rd_we          = 1'b0;
        flags_we       = 1'b0;
        spsr_to_cpsr   = 1'b0;
        flush_req      = 1'b0;
        case (state_q)
            REG_SHIFT: begin
                rs_read    = ~kill;
                latch_op_b = ~kill;
            end
            EXEC: begin
                use_op_b_latch = shift_q;
                done           = ~kill;
                if (!kill) begin
                    if (is_compare) begin
                        flags_we = 1'b1;
                    end else begin
                        rd_we = 1'b1;
                        if (rd_is_pc) begin
                            flush_req    = 1'b1;
                            spsr_to_cpsr = set_flags_q;
                        end else begin
                            flags_we = set_flags_q;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.alu_op         = dp_opcode_to_alu_op(opcode_q);
    assign bus.latch_op_b     = latch_op_b;
    assign bus.use_op_b_latch = use_op_b_latch;
    assign bus.disable_op_b   = 1'b0;
    assign bus.rs_read        = rs_read;
    assign bus.rd_we          = rd_we;
    assign bus.rd_idx         = rd_q;
    assign bus.flags_we       = flags_we;
    assign bus.spsr_to_cpsr   = spsr_to_cpsr;
    assign bus.flush_req      = flush_req;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed bench with a per-cycle expected-output queue model
module tb_alu_sequencer;
    import cpu_types_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        alu_op_t    alu_op;
        logic       latch_op_b;
        logic       use_op_b_latch;
        logic       disable_op_b;
        logic       rs_read;
        logic       rd_we;
        logic [3:0] rd_idx;
        logic       flags_we;
        logic       spsr_to_cpsr;
        logic       flush_req;
    } rec_t;

    alu_op_t op_tab [16] = '{
        ALU_OP_AND, ALU_OP_XOR, ALU_OP_SUB, ALU_OP_SUB_REVERSED,
        ALU_OP_ADD, ALU_OP_ADC, ALU_OP_SBC, ALU_OP_SBC_REVERSED,
        ALU_OP_TEST, ALU_OP_TEST_EXCLUSIVE, ALU_OP_CMP, ALU_OP_CMP_NEG,
        ALU_OP_OR, ALU_OP_MOV, ALU_OP_BIT_CLEAR, ALU_OP_NOT
    };

    rec_t    exp_q [$];
    alu_op_t last_op;
    bit      armed;

    function automatic rec_t idle_rec(input alu_op_t op);
        rec_t r = '0;
        r.alu_op = op;
        return r;
    endfunction

    function automatic rec_t shift_rec(input logic [3:0] op);
        rec_t r = '0;
        r.busy = 1'b1; r.alu_op = op_tab[op]; r.rs_read = 1'b1; r.latch_op_b = 1'b1;
        return r;
    endfunction

    function automatic rec_t exec_rec(input logic [3:0] op, input logic s, input logic sr, input logic [3:0] rd);
        rec_t r = '0;
        r.busy = 1'b1; r.done = 1'b1; r.alu_op = op_tab[op];
        r.use_op_b_latch = sr; r.rd_idx = rd;
        if (op >= 4'h8 && op <= 4'hB) begin
            r.flags_we = 1'b1;
        end else begin
            r.rd_we = 1'b1;
            if (rd == 4'd15) begin
                r.flush_req = 1'b1;
                r.spsr_to_cpsr = s;
            end else begin
                r.flags_we = s;
            end
        end
        return r;
    endfunction

    // model: an accepted instruction becomes one queued record per busy cycle
    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            exp_q.delete();
            last_op = ALU_OP_MOV;
        end else begin
            acc = (exp_q.size() == 0) && bus.start && !bus.cancel;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (bus.cancel) exp_q.delete();
            if (acc) begin
                last_op = op_tab[bus.opcode];
                if (bus.shift_by_reg) exp_q.push_back(shift_rec(bus.opcode));
                exp_q.push_back(exec_rec(bus.opcode, bus.set_flags, bus.shift_by_reg, bus.rd));
            end
        end
        armed = 1'b1;
    end

    always @(negedge clk) begin
        rec_t e, a;
        if (armed) begin
            e = (exp_q.size() != 0) ? exp_q[0] : idle_rec(last_op);
            if (bus.cancel || reset) begin
                e.done = 0; e.latch_op_b = 0; e.rs_read = 0; e.rd_we = 0;
                e.flags_we = 0; e.spsr_to_cpsr = 0; e.flush_req = 0;
            end
            a = '{busy: bus.busy, done: bus.done, alu_op: bus.alu_op,
                  latch_op_b: bus.latch_op_b, use_op_b_latch: bus.use_op_b_latch,
                  disable_op_b: bus.disable_op_b, rs_read: bus.rs_read, rd_we: bus.rd_we,
                  rd_idx: bus.rd_idx, flags_we: bus.flags_we,
                  spsr_to_cpsr: bus.spsr_to_cpsr, flush_req: bus.flush_req};
            if (!e.rd_we) begin
                e.rd_idx = 4'd0;
                a.rd_idx = 4'd0;
            end
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL model_cycle t=%0t actual=%h expected=%h", $time, a, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [3:0] op, input logic s,
                         input logic sr, input logic [3:0] rd);
        bus.start = st; bus.opcode = op; bus.set_flags = s;
        bus.shift_by_reg = sr; bus.rd = rd;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_alu_op"}, bus.alu_op, ALU_OP_MOV);
        chk({tag, "_rd_idx"}, bus.rd_idx, 0);
        chk({tag, "_strobes"}, {bus.done, bus.latch_op_b, bus.use_op_b_latch, bus.disable_op_b,
                                bus.rs_read, bus.rd_we, bus.flags_we, bus.spsr_to_cpsr,
                                bus.flush_req}, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        armed  = 1'b0;
        reset  = 1'b1;
        bus.cancel = 1'b0;
        drive(0, 4'h0, 0, 0, 4'd0);
        step();
        step();
        reset = 1'b0;
        check_reset_values("reset");

        // ADDS r3, immediate
        drive(1, 4'h4, 1, 0, 4'd3);
        step();
        drive(0, 4'h0, 0, 0, 4'd0);
        chk("adds_alu_op", bus.alu_op, ALU_OP_ADD);
        chk("adds_rd_we_idx", {bus.rd_we, bus.rd_idx}, {1'b1, 4'd3});
        chk("adds_flags_done", {bus.flags_we, bus.done, bus.busy}, 3'b111);
        step();
        chk("adds_busy_after", bus.busy, 0);

        // SUB r1 with register shift; start held during REG_SHIFT must be ignored
        drive(1, 4'h2, 0, 1, 4'd1);
        step();
        chk("sub_regshift_rs_latch", {bus.rs_read, bus.latch_op_b, bus.done}, 3'b110);
        chk("sub_alu_op_early", bus.alu_op, ALU_OP_SUB);
        step();
        drive(0, 4'h0, 0, 0, 4'd0);
        chk("sub_exec", {bus.use_op_b_latch, bus.rd_we, bus.flags_we, bus.done}, 4'b1101);
        step();

        // CMP with rd=15
        drive(1, 4'hA, 0, 0, 4'd15);
        step();
        drive(0, 4'h0, 0, 0, 4'd0);
        chk("cmp_exec", {bus.flags_we, bus.rd_we, bus.flush_req, bus.spsr_to_cpsr}, 4'b1000);
        step();

        // MOVS pc
        drive(1, 4'hD, 1, 0, 4'd15);
        step();
        drive(0, 4'h0, 0, 0, 4'd0);
        chk("movs_pc", {bus.rd_we, bus.rd_idx, bus.flush_req, bus.spsr_to_cpsr, bus.flags_we},
            {1'b1, 4'd15, 3'b110});
        step();

        // cancel during REG_SHIFT with start held high
        drive(1, 4'h4, 1, 1, 4'd2);
        step();
        bus.cancel = 1'b1;
        #1;
        chk("cancel_rs_strobes", {bus.rs_read, bus.latch_op_b, bus.done}, 3'b000);
        step();
        bus.cancel = 1'b0;
        chk("cancel_idle", bus.busy, 0);
        step();
        chk("cancel_then_accept", {bus.busy, bus.rs_read}, 2'b11);
        drive(0, 4'h0, 0, 0, 4'd0);
        step();
        step();

        // cancel during EXEC
        drive(1, 4'h4, 1, 0, 4'd5);
        step();
        drive(0, 4'h0, 0, 0, 4'd0);
        bus.cancel = 1'b1;
        #1;
        chk("cancel_exec", {bus.rd_we, bus.flags_we, bus.done}, 3'b000);
        step();
        bus.cancel = 1'b0;
        chk("cancel_exec_idle", bus.busy, 0);

        // reset during EXEC
        drive(1, 4'hE, 1, 0, 4'd7);
        step();
        drive(0, 4'h0, 0, 0, 4'd0);
        reset = 1'b1;
        #1;
        chk("reset_exec_no_strobe", {bus.rd_we, bus.flags_we, bus.done}, 3'b000);
        step();
        reset = 1'b0;
        check_reset_values("reset_exec");

        // sweep all opcodes
        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            bit seen;
            op = 4'(i);
            drive(1, op, op[0], op[1], (i % 3 == 0) ? 4'd15 : op);
            step();
            drive(0, 4'h0, 0, 0, 4'd0);
            seen = 0;
            for (int k = 0; k < 4 && !seen; k++) begin
                if (bus.done) begin
                    seen = 1;
                    chk($sformatf("sweep_alu_op_%0d", i), bus.alu_op, op_tab[i]);
                end else begin
                    step();
                end
            end
            if (!seen) chk($sformatf("sweep_done_timeout_%0d", i), 0, 1);
            step();
            chk($sformatf("sweep_hold_%0d", i), {bus.busy, bus.alu_op}, {1'b0, op_tab[i]});
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
